// File: rtl/rr_mux_arbiter.sv
// rr_mux_arbiter
//   Round-robin arbiter in front of one shared 4:1 data mux. Each cycle one
//   requester is granted, its data is steered through the mux and captured
//   into a single-entry output register. A valid/ready handshake on that
//   register gives 1-cycle latency and one transfer per cycle.
//
// Ports
//   clk        clock, rising edge
//   rst        asynchronous active-high reset
//   req_valid  [3:0] per-requester valid
//   d0..d3     [WIDTH-1:0] per-requester data
//   req_ready  [3:0] one-hot accept for the granted requester (0 if no load)
//   sel        [1:0] current grant index, drives the mux select
//   out_valid  output register holds a beat
//   out_data   [WIDTH-1:0] captured data
//   out_id     [1:0] requester that supplied out_data
//   out_ready  consumer accepts when out_valid && out_ready
module rr_mux_arbiter #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [3:0]       req_valid,
    input  logic [WIDTH-1:0] d0,
    input  logic [WIDTH-1:0] d1,
    input  logic [WIDTH-1:0] d2,
    input  logic [WIDTH-1:0] d3,
    output logic [3:0]       req_ready,
    output logic [1:0]       sel,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    output logic [1:0]       out_id,
    input  logic             out_ready
);

    typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

    state_t           state;
    logic [1:0]       ptr;
    logic             load;
    logic             found;
    logic [WIDTH-1:0] mux_data;

    assign out_valid = (state == FULL);

    // Scan from ptr upward with 2-bit wrap; first valid requester wins.
    // With nobody requesting, sel parks on ptr.
    always_comb begin
        logic [1:0] idx;
        sel   = ptr;
        found = 1'b0;
        for (int k = 0; k < 4; k++) begin
            idx = ptr + 2'(k);
            if (!found && req_valid[idx]) begin
                sel   = idx;
                found = 1'b1;
            end
        end
    end

    always_comb begin
        case (sel)
            2'd0:    mux_data = d0;
            2'd1:    mux_data = d1;
            2'd2:    mux_data = d2;
            default: mux_data = d3;
        endcase
    end

    // A slot is available when empty or when the current beat drains this
    // cycle. Gated by rst so nothing is acknowledged while in reset.
    assign load = !rst && (|req_valid) && (!out_valid || out_ready);

    always_comb begin
        req_ready = 4'b0000;
        if (load)
            req_ready[sel] = 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= EMPTY;
            out_data <= '0;
            out_id   <= 2'd0;
            ptr      <= 2'd0;
        end else begin
            case (state)
                EMPTY: begin
                    if (load) begin
                        state    <= FULL;
                        out_data <= mux_data;
                        out_id   <= sel;
                        ptr      <= sel + 2'd1;
                    end
                end
                FULL: begin
                    // Drain and refill on the same edge keeps FULL with no bubble.
                    if (load) begin
                        out_data <= mux_data;
                        out_id   <= sel;
                        ptr      <= sel + 2'd1;
                    end else if (out_ready) begin
                        state <= EMPTY;
                    end
                end
                default: state <= EMPTY;
            endcase
        end
    end

endmodule
